// File: rtl/adam_axil_responder_if.sv
// ----------------------------------------------------------------------------
// adam_axil_responder_if
// AXI-Lite bus bundle between a fabric master port and an AXI-Lite slave
// endpoint such as adam_axil_responder.
//
// Parameters:
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  data width; strobe width is DATA_WIDTH/8
//
// Signals (direction given for the slave modport):
//   aw_addr/aw_prot/aw_valid in,  aw_ready out   write address channel
//   w_data/w_strb/w_valid    in,  w_ready  out   write data channel
//   b_resp/b_valid           out, b_ready  in    write response channel
//   ar_addr/ar_prot/ar_valid in,  ar_ready out   read address channel
//   r_data/r_resp/r_valid    out, r_ready  in    read data/response channel
// ----------------------------------------------------------------------------
interface adam_axil_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [2:0]            aw_prot;
    logic                  aw_valid;
    logic                  aw_ready;

    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_valid;
    logic                  w_ready;

    logic [1:0]            b_resp;
    logic                  b_valid;
    logic                  b_ready;

    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [2:0]            ar_prot;
    logic                  ar_valid;
    logic                  ar_ready;

    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_valid;
    logic                  r_ready;

    modport master (
        output aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );

    modport slave (
        input  aw_addr, aw_prot, aw_valid, w_data, w_strb, w_valid, b_ready,
               ar_addr, ar_prot, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/adam_axil_responder.sv
// ----------------------------------------------------------------------------
// adam_axil_responder
// AXI-Lite slave endpoint that turns fabric transactions into single-port
// word-memory requests (req/gnt, rvalid). One transaction is in flight at a
// time; reads and writes share the memory port with alternating priority on
// ties. The ADAM pause handshake lets the sequencer quiesce the endpoint.
//
// Optional feature macro: ADAM_AXIL_RESP_ERR_EN
//   defined   - accesses above the memory window skip the memory and answer
//               SLVERR (read data 0)
//   undefined - upper address bits are ignored, the window aliases, and the
//               response is always OKAY
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   pause_req_i    pause request
//   pause_ack_o    pause acknowledge (high while quiesced)
//   slv            AXI-Lite slave side (adam_axil_responder_if.slave)
//   mem_req_o      memory request valid
//   mem_we_o       1 = write, 0 = read
//   mem_addr_o     memory word address
//   mem_be_o       byte enables (write strobes, all ones on reads)
//   mem_wdata_o    write data
//   mem_gnt_i      memory accepted the request this cycle
//   mem_rvalid_i   read data valid
//   mem_rdata_i    read data
// ----------------------------------------------------------------------------
module adam_axil_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      pause_req_i,
    output logic                      pause_ack_o,
    adam_axil_responder_if.slave      slv,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(STRB_WIDTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        PAUSED, IDLE, WR_REQ, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
    } state_e;

    state_e                    state_q, state_d;
    logic                      prioWrite_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic [STRB_WIDTH-1:0]     be_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                resp_q;

    logic wrPending, rdPending, acceptWr, acceptRd;
    logic wrErr, rdErr;
    logic unused_bits;

    // Protection bits carry no meaning here and the byte-offset/upper address
    // bits are only partly consumed; fold them so nothing dangles.
    assign unused_bits = ^{slv.aw_prot, slv.ar_prot, slv.aw_addr, slv.ar_addr};

`ifdef ADAM_AXIL_RESP_ERR_EN
    assign wrErr = |slv.aw_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+OFFS];
    assign rdErr = |slv.ar_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+OFFS];
`else
    assign wrErr = 1'b0;
    assign rdErr = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus arbitration. A write is only pending once both AW and W
    // are valid, so they are always taken in one joint handshake. Pause is
    // honoured only from IDLE, letting an open transaction finish first.
    always_comb begin
        wrPending = slv.aw_valid && slv.w_valid;
        rdPending = slv.ar_valid;
        acceptWr  = 1'b0;
        acceptRd  = 1'b0;
        state_d   = state_q;
        case (state_q)
            PAUSED: begin
                if (!pause_req_i) state_d = IDLE;
            end
            IDLE: begin
                if (pause_req_i) begin
                    state_d = PAUSED;
                end else if (wrPending && (!rdPending || prioWrite_q)) begin
                    acceptWr = 1'b1;
                    state_d  = wrErr ? WR_RESP : WR_REQ;
                end else if (rdPending) begin
                    acceptRd = 1'b1;
                    state_d  = rdErr ? RD_RESP : RD_REQ;
                end
            end
            WR_REQ:  if (mem_gnt_i)    state_d = WR_RESP;
            RD_REQ:  if (mem_gnt_i)    state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid_i) state_d = RD_RESP;
            WR_RESP: if (slv.b_ready)  state_d = IDLE;
            RD_RESP: if (slv.r_ready)  state_d = IDLE;
            default: state_d = PAUSED;
        endcase
    end

    // Outputs decoded from state; readys only look at the AXI valids and the
    // pause request, never at the memory side.
    always_comb begin
        pause_ack_o  = (state_q == PAUSED);
        slv.aw_ready = acceptWr;
        slv.w_ready  = acceptWr;
        slv.ar_ready = acceptRd;
        slv.b_valid  = (state_q == WR_RESP);
        slv.r_valid  = (state_q == RD_RESP);
        slv.b_resp   = resp_q;
        slv.r_resp   = resp_q;
        slv.r_data   = rdata_q;
        mem_req_o    = (state_q == WR_REQ) || (state_q == RD_REQ);
        mem_we_o     = (state_q == WR_REQ);
        mem_addr_o   = addr_q;
        mem_be_o     = be_q;
        mem_wdata_o  = wdata_q;
    end

    // Transaction registers. The priority bit only moves when both kinds were
    // pending, so the next tie goes to the type that lost the previous tie;
    // uncontested grants leave it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prioWrite_q <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
        end else begin
            if (acceptWr) begin
                addr_q  <= slv.aw_addr[MEM_ADDR_WIDTH+OFFS-1:OFFS];
                wdata_q <= slv.w_data;
                be_q    <= slv.w_strb;
                resp_q  <= wrErr ? RESP_SLVERR : RESP_OKAY;
                if (rdPending) prioWrite_q <= 1'b0;
            end
            if (acceptRd) begin
                addr_q  <= slv.ar_addr[MEM_ADDR_WIDTH+OFFS-1:OFFS];
                be_q    <= '1;
                rdata_q <= '0;
                resp_q  <= rdErr ? RESP_SLVERR : RESP_OKAY;
                if (wrPending) prioWrite_q <= 1'b1;
            end
            if (state_q == RD_WAIT && mem_rvalid_i) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end
endmodule
